// File: rtl/spi_ram_pkg.sv
// Shared opcodes, default address width and FSM state encoding for the SPI RAM responder.
package spi_ram_pkg;

  localparam int ADDR_W_DEFAULT = 16;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_READ   = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_IGNORE = 3'd5;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronises cs_n/sck/mosi into the clk domain and emits registered edge pulses.
// Pulses stay quiet until the chain has refilled after reset, so a cs_n already low is not seen as a fall.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cs_n,
  input  logic i_sck,
  input  logic i_mosi,
  output logic o_cs_n,
  output logic o_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_fall,
  output logic o_cs_rise
);

  localparam int LW = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0] r_cs_s;
  logic [SYNC_STAGES-1:0] r_sck_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic [LW-1:0]          r_live;
  logic                   r_cs_prev;
  logic                   r_sck_prev;

  logic w_cs;
  logic w_sck;
  logic w_mosi;
  logic w_live;

  assign w_cs   = r_cs_s[SYNC_STAGES-1];
  assign w_sck  = r_sck_s[SYNC_STAGES-1];
  assign w_mosi = r_mosi_s[SYNC_STAGES-1];
  assign w_live = r_live[LW-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cs_s     <= '1;
      r_sck_s    <= '0;
      r_mosi_s   <= '0;
      r_live     <= '0;
      r_cs_prev  <= 1'b1;
      r_sck_prev <= 1'b0;
      o_cs_n     <= 1'b1;
      o_mosi     <= 1'b0;
      o_sck_rise <= 1'b0;
      o_sck_fall <= 1'b0;
      o_cs_fall  <= 1'b0;
      o_cs_rise  <= 1'b0;
    end else begin
      r_cs_s     <= SYNC_STAGES'({r_cs_s, i_cs_n});
      r_sck_s    <= SYNC_STAGES'({r_sck_s, i_sck});
      r_mosi_s   <= SYNC_STAGES'({r_mosi_s, i_mosi});
      r_live     <= LW'({r_live, 1'b1});
      r_cs_prev  <= w_cs;
      r_sck_prev <= w_sck;
      o_cs_n     <= w_cs;
      o_mosi     <= w_mosi;
      o_sck_rise <= w_live & w_sck & ~r_sck_prev;
      o_sck_fall <= w_live & ~w_sck & r_sck_prev;
      o_cs_fall  <= w_live & ~w_cs & r_cs_prev;
      o_cs_rise  <= w_live & w_cs & ~r_cs_prev;
    end
  end

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 target emulating the fetch RAM: READ/WRITE opcode, ADDR_W-bit address, then a byte stream
// served from or stored to a one-cycle synchronous memory port, with auto-increment between bytes.
module spi_ram_responder #(
  parameter int         ADDR_W      = spi_ram_pkg::ADDR_W_DEFAULT,
  parameter logic [7:0] CMD_READ    = spi_ram_pkg::CMD_READ,
  parameter logic [7:0] CMD_WRITE   = spi_ram_pkg::CMD_WRITE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cmd_err
);

  import spi_ram_pkg::*;

  localparam int CNT_W = $clog2(ADDR_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_W - 1);

  logic w_cs_n, w_mosi, w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cs_n     (spi_cs_n),
    .i_sck      (spi_sck),
    .i_mosi     (spi_mosi),
    .o_cs_n     (w_cs_n),
    .o_mosi     (w_mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_fall  (w_cs_fall),
    .o_cs_rise  (w_cs_rise)
  );

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_shift;
  logic              r_is_read;
  logic              r_addr_done;
  logic              r_inc;
  logic              r_re_d;
  logic [7:0]        r_tx;
  logic              r_miso;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [7:0]        r_wdata;
  logic              r_busy;
  logic              r_cmd_err;

  logic [7:0]        w_rx_byte;
  logic [ADDR_W-1:0] w_shift_nxt;

  assign w_rx_byte   = {r_shift[6:0], w_mosi};
  assign w_shift_nxt = {r_shift[ADDR_W-2:0], w_mosi};

  assign spi_miso  = r_miso;
  assign mem_addr  = r_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign cmd_err   = r_cmd_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_is_read   <= 1'b0;
      r_addr_done <= 1'b0;
      r_inc       <= 1'b0;
      r_re_d      <= 1'b0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_addr      <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_cmd_err <= 1'b0;
      // Read data lands one clk after the strobe; capture it well before the next sck fall.
      r_re_d    <= r_mem_re;
      if (r_re_d) r_tx <= mem_rdata;
      if (r_inc) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_inc  <= 1'b0;
      end

      if (w_cs_n | w_cs_rise) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_miso      <= 1'b0;
        r_busy      <= 1'b0;
        r_addr_done <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state <= ST_CMD;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
            end
          end
          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift <= w_shift_nxt;
              if (r_cnt == LAST_BIT) begin
                r_cnt <= '0;
                if (w_rx_byte == CMD_READ || w_rx_byte == CMD_WRITE) begin
                  r_state   <= ST_ADDR;
                  r_is_read <= (w_rx_byte == CMD_READ);
                end else begin
                  r_state   <= ST_IGNORE;
                  r_cmd_err <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_ADDR: begin
            if (r_addr_done) begin
              r_addr_done <= 1'b0;
              r_addr      <= r_shift;
              r_mem_re    <= r_is_read;
              r_state     <= r_is_read ? ST_READ : ST_WRITE;
            end else if (w_sck_rise) begin
              r_shift <= w_shift_nxt;
              if (r_cnt == LAST_ADDR) begin
                r_cnt       <= '0;
                r_addr_done <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_READ: begin
            if (w_sck_fall) begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
            // Prefetch the next byte as soon as the current one has been clocked out.
            if (w_sck_rise) begin
              if (r_cnt == LAST_BIT) begin
                r_cnt    <= '0;
                r_addr   <= r_addr + ADDR_W'(1);
                r_mem_re <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_WRITE: begin
            if (w_sck_rise) begin
              r_shift <= w_shift_nxt;
              if (r_cnt == LAST_BIT) begin
                r_cnt    <= '0;
                r_wdata  <= w_rx_byte;
                r_mem_we <= 1'b1;
                r_inc    <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_IGNORE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: SPI controller tasks, a behavioural RAM, and a reference memory image.
module tb_spi_ram_responder;

  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        cmd_err;

  always #5 clk = ~clk;

  spi_ram_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] re_q[$];
  logic [15:0] we_a_q[$];
  logic [7:0]  we_d_q[$];
  int          both_cnt = 0;
  int          err_cnt = 0;

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] wr_dat[$];

  function automatic logic [7:0] pat(input int a);
    case (a)
      5:  return 8'hA7;
      16: return 8'h11;
      17: return 8'h22;
      18: return 8'h33;
      default: return 8'(a * 37) ^ 8'(a >> 8) ^ 8'h5A;
    endcase
  endfunction

  // RAM with a one-clk read latency; read data holds until the next read.
  initial begin : mem_model
    for (int i = 0; i < 65536; i++) ram[i] = pat(i);
    mem_rdata <= 8'h00;
    forever begin
      @(posedge clk);
      if (mem_re) mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_re) re_q.push_back(mem_addr);
    if (mem_we) begin
      we_a_q.push_back(mem_addr);
      we_d_q.push_back(mem_wdata);
    end
    if (mem_re && mem_we) both_cnt++;
    if (cmd_err) err_cnt++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    re_q.delete();
    we_a_q.delete();
    we_d_q.delete();
  endtask

  task automatic xfer_bit(input logic b, output logic m);
    spi_mosi = b;
    clk_wait(HP);
    spi_sck = 1'b1;
    m = spi_miso;
    clk_wait(HP);
    spi_sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] b, output logic [7:0] m);
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], m[i]);
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    clk_wait(HP);
  endtask

  task automatic cs_end();
    clk_wait(HP);
    spi_cs_n = 1'b1;
    clk_wait(2 * HP);
  endtask

  task automatic run_read(input logic [15:0] a, input int n, input string tag);
    logic [7:0]  m;
    logic [15:0] ea;
    clear_mon();
    cs_begin();
    xfer_byte(8'h03, m);
    xfer_byte(a[15:8], m);
    xfer_byte(a[7:0], m);
    n_cmp++;
    if (re_q.size() != 1 || re_q[0] !== a) begin
      n_bad++;
      $display("FAIL %s first_re: got %0d strobes first=%h, want 1 at %h", tag, re_q.size(), re_q[0], a);
    end
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'($urandom), m);
      ea = a + 16'(i);
      n_cmp++;
      if (m !== ref_mem[ea]) begin
        n_bad++;
        $display("FAIL %s data[%0d] @%h: got %h want %h", tag, i, ea, m, ref_mem[ea]);
      end
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_active: got %b want 1", tag, busy);
    end
    cs_end();
    n_cmp++;
    if (re_q.size() < n || re_q.size() > n + 1) begin
      n_bad++;
      $display("FAIL %s re_count: got %0d want %0d or %0d", tag, re_q.size(), n, n + 1);
    end else begin
      for (int i = 0; i < re_q.size(); i++) begin
        ea = a + 16'(i);
        n_cmp++;
        if (re_q[i] !== ea) begin
          n_bad++;
          $display("FAIL %s re_addr[%0d]: got %h want %h", tag, i, re_q[i], ea);
        end
      end
    end
    n_cmp++;
    if (we_a_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_after: we=%0d busy=%b want we=0 busy=0", tag, we_a_q.size(), busy);
    end
  endtask

  task automatic run_write(input logic [15:0] a, input string tag);
    logic [7:0]  m;
    logic [15:0] ea;
    clear_mon();
    cs_begin();
    xfer_byte(8'h02, m);
    xfer_byte(a[15:8], m);
    xfer_byte(a[7:0], m);
    foreach (wr_dat[i]) xfer_byte(wr_dat[i], m);
    cs_end();
    n_cmp++;
    if (we_a_q.size() != wr_dat.size() || re_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s strobe_count: we=%0d re=%0d want we=%0d re=0", tag, we_a_q.size(), re_q.size(), wr_dat.size());
    end else begin
      foreach (wr_dat[i]) begin
        ea = a + 16'(i);
        n_cmp++;
        if (we_a_q[i] !== ea || we_d_q[i] !== wr_dat[i]) begin
          n_bad++;
          $display("FAIL %s we[%0d]: got (%h,%h) want (%h,%h)", tag, i, we_a_q[i], we_d_q[i], ea, wr_dat[i]);
        end
      end
    end
    foreach (wr_dat[i]) ref_mem[a + 16'(i)] = wr_dat[i];
  endtask

  task automatic test_reset();
    clk_wait(3);
    n_cmp++;
    if ({spi_miso, mem_re, mem_we, busy, cmd_err, mem_addr, mem_wdata} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: miso=%b re=%b we=%b busy=%b err=%b addr=%h wdata=%h want all 0",
               spi_miso, mem_re, mem_we, busy, cmd_err, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    clk_wait(2 * HP);
  endtask

  task automatic test_single_read();
    run_read(16'h0005, 1, "single_read");
  endtask

  task automatic test_burst();
    run_read(16'h0010, 3, "burst_fixed");
    for (int k = 0; k < 4; k++) run_read(16'($urandom), $urandom_range(1, 4), "burst_rand");
  endtask

  task automatic test_write();
    wr_dat = '{8'h5A, 8'hC3};
    run_write(16'h0120, "write_fixed");
    run_read(16'h0120, 2, "write_readback");
    for (int k = 0; k < 3; k++) begin
      logic [15:0] a;
      a = (k == 0) ? 16'hFFFE : 16'($urandom);
      wr_dat.delete();
      repeat ($urandom_range(1, 3)) wr_dat.push_back(8'($urandom));
      run_write(a, "write_rand");
      run_read(a, wr_dat.size(), "write_rand_rb");
    end
  endtask

  task automatic test_wrap();
    run_read(16'hFFFF, 2, "wrap");
  endtask

  task automatic test_abort();
    logic [7:0] m;
    logic       b;
    clear_mon();
    cs_begin();
    xfer_byte(8'h03, m);
    xfer_byte(8'($urandom), m);
    for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), b);
    clk_wait(HP);
    spi_cs_n = 1'b1;
    clk_wait(4 * HP);
    n_cmp++;
    if (re_q.size() != 0 || we_a_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: re=%0d we=%0d busy=%b want 0 0 0", re_q.size(), we_a_q.size(), busy);
    end
    run_read(16'h0005, 1, "after_abort");
  endtask

  task automatic test_bad_opcode();
    logic [7:0] m;
    logic       b;
    logic       any_miso;
    int         e0;
    clear_mon();
    e0 = err_cnt;
    any_miso = 1'b0;
    cs_begin();
    xfer_byte(8'h9F, m);
    for (int i = 0; i < 16; i++) begin
      xfer_bit(1'($urandom), b);
      any_miso |= b;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_op_busy: got %b want 1", busy);
    end
    cs_end();
    n_cmp++;
    if (err_cnt - e0 != 1) begin
      n_bad++;
      $display("FAIL bad_op_err_pulses: got %0d want 1", err_cnt - e0);
    end
    n_cmp++;
    if (any_miso !== 1'b0 || re_q.size() != 0 || we_a_q.size() != 0) begin
      n_bad++;
      $display("FAIL bad_op_quiet: miso_seen=%b re=%0d we=%0d want 0 0 0", any_miso, re_q.size(), we_a_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] m;
    logic       b;
    logic       any_miso;
    clear_mon();
    cs_begin();
    xfer_byte(8'h03, m);
    xfer_byte(8'h00, m);
    xfer_byte(8'h10, m);
    xfer_byte(8'h00, m);
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, b);
    rst_n = 1'b0;
    clk_wait(1);
    rst_n = 1'b1;
    n_cmp++;
    if ({spi_miso, mem_re, mem_we, busy, cmd_err, mem_addr, mem_wdata} !== 29'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: miso=%b re=%b we=%b busy=%b err=%b addr=%h wdata=%h want all 0",
               spi_miso, mem_re, mem_we, busy, cmd_err, mem_addr, mem_wdata);
    end
    clear_mon();
    any_miso = 1'b0;
    for (int i = 0; i < 13; i++) begin
      xfer_bit(1'($urandom), b);
      any_miso |= b;
    end
    n_cmp++;
    if (any_miso !== 1'b0 || busy !== 1'b0 || re_q.size() != 0 || we_a_q.size() != 0) begin
      n_bad++;
      $display("FAIL mid_reset_ignored: miso_seen=%b busy=%b re=%0d we=%0d want 0 0 0 0",
               any_miso, busy, re_q.size(), we_a_q.size());
    end
    cs_end();
    run_read(16'h0010, 3, "after_mid_reset");
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    test_reset();
    test_single_read();
    test_burst();
    test_write();
    test_wrap();
    test_abort();
    test_bad_opcode();
    test_reset_mid_read();
    n_cmp++;
    if (both_cnt != 0 || err_cnt != 1) begin
      n_bad++;
      $display("FAIL global: re_and_we_cycles=%0d cmd_err_pulses=%0d want 0 and 1", both_cnt, err_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
